// File: rtl/ram_access_unit.sv
// ram_access_unit: multi-cycle access engine for a 128 x 8 internal RAM.
// It handles register, indirect, direct, immediate, bit and stack accesses.
// Optional build macro RAM_STACK_GUARD_EN adds stack overflow/underflow
// protection and the sticky stk_err flag.
module ram_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ram_load,
  input  logic [3:0]  ram_access,
  input  logic [2:0]  reg_sel,
  input  logic [1:0]  rs,
  input  logic [7:0]  operand,
  input  logic [1:0]  bit_op,
  input  logic [7:0]  acc_in,
  input  logic [15:0] pc_in,
  output logic        busy,
  output logic        data_valid,
  output logic [7:0]  data_out,
  output logic [15:0] pc_out,
  output logic [7:0]  sp,
  output logic        stk_err
);

  localparam logic [3:0] RD_REG     = 4'd1;
  localparam logic [3:0] WR_REG     = 4'd2;
  localparam logic [3:0] WR_REG_IM  = 4'd3;
  localparam logic [3:0] RD_REG_IND = 4'd4;
  localparam logic [3:0] WR_REG_IND = 4'd5;
  localparam logic [3:0] RD_DIRECT  = 4'd6;
  localparam logic [3:0] WR_DIRECT  = 4'd7;
  localparam logic [3:0] RD_IM      = 4'd8;
  localparam logic [3:0] WR_BIT     = 4'd9;
  localparam logic [3:0] RD_STACK   = 4'd10;
  localparam logic [3:0] WR_STACK   = 4'd11;

  typedef enum logic [2:0] {IDLE, ADDR, IND, ACCESS, ACCESS2, DONE} state_t;

  state_t      state, next_state;
  logic [7:0]  mem [0:127];

  logic [3:0]  code_q;
  logic [6:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  operand_q;
  logic [1:0]  bit_op_q;
  logic [15:0] pc_q;
  logic [7:0]  byte_q;
  logic [7:0]  high_q;

  logic        valid_code;
  logic [6:0]  eff_addr;
  logic        stack_fault;
  logic [6:0]  sp_p1, sp_p2, sp_m1;
  logic [7:0]  bit_mask, bit_byte;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  assign valid_code = (ram_access >= RD_REG) && (ram_access <= WR_STACK);
  assign sp_p1      = sp[6:0] + 7'd1;
  assign sp_p2      = sp[6:0] + 7'd2;
  assign sp_m1      = sp[6:0] - 7'd1;
  assign bit_mask   = 8'd1 << operand_q[2:0];
  assign rd_data    = mem[rd_addr];

  // Effective address of the request currently on the inputs; for indirect
  // codes this is the address of R0/R1, which IND then dereferences.
  always_comb begin
    eff_addr = 7'd0;
    case (ram_access)
      RD_REG, WR_REG, WR_REG_IM: eff_addr = {2'b00, rs, reg_sel};
      RD_REG_IND, WR_REG_IND:    eff_addr = {2'b00, rs, 2'b00, reg_sel[0]};
      RD_DIRECT, WR_DIRECT:      eff_addr = operand[6:0];
      WR_BIT:                    eff_addr = {3'b010, operand[6:3]};
      default:                   eff_addr = 7'd0;
    endcase
  end

  // Stack bounds check on the latched code; without the guard it never trips.
  always_comb begin
`ifdef RAM_STACK_GUARD_EN
    stack_fault = ((code_q == WR_STACK) && (sp > 8'h7D)) ||
                  ((code_q == RD_STACK) && (sp < 8'h09));
`else
    stack_fault = 1'b0;
`endif
  end

  // Read-modify-write value for the bit instruction.
  always_comb begin
    case (bit_op_q)
      2'd0:    bit_byte = byte_q & ~bit_mask;
      2'd1:    bit_byte = byte_q | bit_mask;
      2'd2:    bit_byte = byte_q ^ bit_mask;
      default: bit_byte = byte_q;
    endcase
  end

  // RAM read port address: stack codes read around SP, all others the latched address.
  always_comb begin
    rd_addr = addr_q;
    if (code_q == RD_STACK) begin
      if (state == ACCESS)       rd_addr = sp[6:0];
      else if (state == ACCESS2) rd_addr = sp_m1;
    end
  end

  // RAM write port; suppressed while reset is high so an aborted access never lands.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    if (!reset) begin
      if (state == ACCESS) begin
        case (code_q)
          WR_REG, WR_REG_IM, WR_REG_IND, WR_DIRECT: mem_we = 1'b1;
          WR_STACK: begin
            mem_we    = !stack_fault;
            mem_waddr = sp_p1;
            mem_wdata = pc_q[7:0];
          end
          default: mem_we = 1'b0;
        endcase
      end else if (state == ACCESS2) begin
        case (code_q)
          WR_BIT: begin
            mem_we    = !operand_q[7];
            mem_wdata = bit_byte;
          end
          WR_STACK: begin
            mem_we    = !stack_fault;
            mem_waddr = sp_p2;
            mem_wdata = pc_q[15:8];
          end
          default: mem_we = 1'b0;
        endcase
      end
    end
  end

  // RAM storage; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: the path length depends on the access code.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ram_load && valid_code) next_state = ADDR;
      ADDR:    next_state = ((code_q == RD_REG_IND) || (code_q == WR_REG_IND)) ? IND : ACCESS;
      IND:     next_state = ACCESS;
      ACCESS:  next_state = ((code_q == WR_BIT) || (code_q == WR_STACK) || (code_q == RD_STACK))
                            ? ACCESS2 : DONE;
      ACCESS2: next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy       = (state != IDLE);
    data_valid = (state == DONE);
  end

  // Datapath: request capture at the accepting edge, then per-state results and SP update.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out  <= 8'd0;
      pc_out    <= 16'd0;
      sp        <= 8'h07;
      code_q    <= 4'd0;
      addr_q    <= 7'd0;
      wdata_q   <= 8'd0;
      operand_q <= 8'd0;
      bit_op_q  <= 2'd0;
      pc_q      <= 16'd0;
      byte_q    <= 8'd0;
      high_q    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_load && valid_code) begin
            code_q    <= ram_access;
            addr_q    <= eff_addr;
            wdata_q   <= (ram_access == WR_REG_IM) ? operand : acc_in;
            operand_q <= operand;
            bit_op_q  <= bit_op;
            pc_q      <= pc_in;
          end
        end
        IND: addr_q <= rd_data[6:0];
        ACCESS: begin
          case (code_q)
            RD_REG, RD_REG_IND, RD_DIRECT:            data_out <= rd_data;
            WR_REG, WR_REG_IM, WR_REG_IND, WR_DIRECT: data_out <= wdata_q;
            RD_IM:                                    data_out <= operand_q;
            WR_BIT:                                   byte_q   <= rd_data;
            RD_STACK:                                 high_q   <= rd_data;
            default:                                  ;
          endcase
        end
        ACCESS2: begin
          case (code_q)
            WR_BIT:   data_out <= operand_q[7] ? 8'd0 : bit_byte;
            WR_STACK: data_out <= stack_fault ? 8'd0 : pc_q[15:8];
            RD_STACK: begin
              if (stack_fault) begin
                data_out <= 8'd0;
              end else begin
                data_out <= high_q;
                pc_out   <= {high_q, rd_data};
              end
            end
            default: ;
          endcase
        end
        DONE: begin
          if (!stack_fault) begin
            if (code_q == WR_STACK)      sp <= sp + 8'd2;
            else if (code_q == RD_STACK) sp <= sp - 8'd2;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_STACK_GUARD_EN
  logic stk_err_q;

  // Sticky stack error, raised when a guarded stack access completes.
  always_ff @(posedge clock) begin
    if (reset)                              stk_err_q <= 1'b0;
    else if ((state == DONE) && stack_fault) stk_err_q <= 1'b1;
  end

  assign stk_err = stk_err_q;
`else
  assign stk_err = 1'b0;
`endif

endmodule

// File: doc/ram_access_unit.md
RAM_ACCESS_UNIT -- requirements
Module: ram_access_unit

Interface
REQ-001 clock  input  1  rising-edge system clock.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 ram_load  input  1  access strobe from control unit; sampled only in IDLE.
REQ-004 ram_access  input  4  access code: 0 NONE, 1 RD_REG, 2 WR_REG, 3 WR_REG_IM, 4 RD_REG_IND, 5 WR_REG_IND, 6 RD_DIRECT, 7 WR_DIRECT, 8 RD_IM, 9 WR_BIT, 10 RD_STACK, 11 WR_STACK; 12-15 treated as NONE.
REQ-005 reg_sel  input  3  Rn index (opcode[2:0]); bit 0 selects R0/R1 for indirect codes.
REQ-006 rs  input  2  register bank select (PSW.RS1:RS0).
REQ-007 operand  input  8  second instruction byte: direct address, immediate, or bit address.
REQ-008 bit_op  input  2  for WR_BIT: 0 CLR, 1 SETB, 2 CPL, 3 no change.
REQ-009 acc_in  input  8  accumulator value for write codes other than WR_REG_IM.
REQ-010 pc_in  input  16  return address for WR_STACK.
REQ-011 busy  output  1  high from the cycle after acceptance until DONE inclusive.
REQ-012 data_valid  output  1  one-cycle pulse in DONE.
REQ-013 data_out  output  8  read result; holds until next DONE.
REQ-014 pc_out  output  16  popped address after RD_STACK; holds until next RD_STACK DONE.
REQ-015 sp  output  8  stack pointer.
REQ-016 stk_err  output  1  sticky stack error (STACK_GUARD_EN only; else constant 0).

Function
REQ-017 Storage: 128 x 8 internal RAM; every address uses [6:0] (wraps mod 128).
REQ-018 FSM states IDLE, ADDR, IND, ACCESS, ACCESS2, DONE; IDLE->ADDR when ram_load=1 and code != NONE; NONE or idle strobe stays IDLE.
REQ-019 ADDR latches all inputs and the effective address; subsequent input changes are ignored.
REQ-020 REG codes: address {rs,reg_sel}; path ADDR->ACCESS->DONE (data_valid 3 cycles after accepting edge).
REQ-021 IND codes: ADDR reads Ri at {rs,2'b0,reg_sel[0]}, IND uses its [6:0] as address, then ACCESS->DONE (latency 4).
REQ-022 DIRECT codes: address operand[6:0]; latency 3.
REQ-023 RD_IM: no RAM access; data_out=operand; latency 3.
REQ-024 WR_REG_IM writes operand; all other writes use acc_in.
REQ-025 WR_BIT: byte 0x20+operand[6:3], bit operand[2:0]; ACCESS reads, ACCESS2 writes modified byte; data_out = new byte; latency 4; operand[7]=1 (SFR bit) performs no write, data_out=0.
REQ-026 WR_STACK: ACCESS writes pc_in[7:0] at SP+1, ACCESS2 writes pc_in[15:8] at SP+2; SP+=2 in DONE; latency 4.
REQ-027 RD_STACK: ACCESS reads high at SP, ACCESS2 reads low at SP-1; pc_out={high,low}, data_out=high; SP-=2 in DONE; latency 4.
REQ-028 SP arithmetic is 8-bit modulo 256; RAM index uses SP[6:0].
REQ-029 DONE always returns to IDLE; ram_load during busy or DONE is ignored (no queueing); next accepted at earliest in the cycle after DONE.
REQ-030 Read results for write codes: data_out = value written.

Reset
REQ-031 reset forces IDLE, busy=0, data_valid=0, data_out=0, pc_out=0, sp=0x07, stk_err=0.
REQ-032 reset has priority over all transitions; reset mid-operation aborts with no further RAM write and no SP update.
REQ-033 RAM contents are not cleared by reset.

Configuration
REQ-034 Macro RAM_STACK_GUARD_EN defined: WR_STACK with SP>0x7D or RD_STACK with SP<0x09 performs no RAM write/SP change, sets stk_err (cleared only by reset), still pulses data_valid with data_out=0.
REQ-035 Macro undefined: no checks, SP wraps per REQ-028, stk_err tied 0.

Verification
REQ-036 reset; rs=1, reg_sel=3, WR_REG, acc_in=0x5A; then RD_REG -> RAM[0x0B]=0x5A, data_out=0x5A, data_valid 3 cycles after strobe.
REQ-037 RAM[0x00]=0x40 via WR_REG (rs=0,reg_sel=0); WR_REG_IND acc_in=0x99; RD_DIRECT operand=0x40 -> data_out=0x99; indirect latency 4.
REQ-038 RAM[0x24]=0x00; WR_BIT operand=0x23 bit_op=1 -> RAM[0x24]=0x08; repeat bit_op=2 -> 0x00.
REQ-039 reset, WR_STACK pc_in=0x1234 -> RAM[0x08]=0x34, RAM[0x09]=0x12, sp=0x09; RD_STACK -> pc_out=0x1234, sp=0x07.
REQ-040 reset asserted in ACCESS of WR_DIRECT -> target byte unchanged, sp=0x07, busy=0; strobe while busy ignored.
REQ-041 guard build: reset, RD_STACK -> stk_err=1, sp=0x07; non-guard build: sp=0x05.
